mem_arbiter: RTL and testbench

Arbitrates the single shared RAM port between the instruction cache (read-only) and the data cache (read/write) inside the cache subsystem. Each cache presents a request and is stalled on its own wait line until the RAM completes its transfer. A registered three-state controller serves one requester at a time. Ties alternate between requesters so that neither cache starves.

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the shared RAM port and mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the
// view of the surrounding logic (caches plus RAM) that drives the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // icache side
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;

    // dcache side
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;

    // shared RAM port
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ramready;

    modport slave (
        input  iREN, iaddr,
        input  dREN, dWEN, daddr, dstore,
        input  ramload, ramready,
        output iwait, iload,
        output dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr,
        output dREN, dWEN, daddr, dstore,
        output ramload, ramready,
        input  iwait, iload,
        input  dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter for the icache (read-only) and dcache (read/write).
// One requester is served at a time by a three-state controller. Every
// completion or abort is followed by one IDLE bubble so a finished request
// is never re-issued. Ties in IDLE alternate using the 'last' grant record.
// Address/data are not latched: the served cache holds them until its wait
// goes low, and the RAM port is driven combinationally from the serve state.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISERV = 2'd1,
        DSERV = 2'd2
    } state_t;

    typedef enum logic {
        LAST_I = 1'b0,
        LAST_D = 1'b1
    } grant_t;

    state_t state, state_nxt;
    grant_t last,  last_nxt;

    logic              dreq;
    logic              ren_c;
    logic              wen_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] store_c;
    logic              iwait_c;
    logic              dwait_c;

    assign dreq = bus.dREN | bus.dWEN;

    // State and grant record; async reset leaves last=D so the first tie goes to the icache.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            last  <= LAST_D;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Next-state selection and RAM/wait outputs for the current serve state.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        ren_c     = 1'b0;
        wen_c     = 1'b0;
        addr_c    = '0;
        store_c   = '0;
        iwait_c   = 1'b1;
        dwait_c   = 1'b1;

        case (state)
            IDLE: begin
                // ramready is deliberately ignored here.
                if (dreq && (!bus.iREN || last == LAST_I)) begin
                    state_nxt = DSERV;
                    last_nxt  = LAST_D;
                end else if (bus.iREN) begin
                    state_nxt = ISERV;
                    last_nxt  = LAST_I;
                end
            end

            ISERV: begin
                ren_c   = 1'b1;
                addr_c  = bus.iaddr;
                iwait_c = ~bus.ramready;
                // Completion, or abort when the icache withdraws before ready.
                if (bus.ramready || !bus.iREN) begin
                    state_nxt = IDLE;
                end
            end

            DSERV: begin
                // A write wins when both dcache strobes are high.
                wen_c   = bus.dWEN;
                ren_c   = bus.dREN & ~bus.dWEN;
                addr_c  = bus.daddr;
                store_c = bus.dstore;
                dwait_c = ~bus.ramready;
                // Completion, or abort when the dcache withdraws before ready.
                if (bus.ramready || !dreq) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.ramREN   = ren_c;
    assign bus.ramWEN   = wen_c;
    assign bus.ramaddr  = addr_c;
    assign bus.ramstore = store_c;
    assign bus.iwait    = iwait_c;
    assign bus.dwait    = dwait_c;

    // Read data is a straight pass-through; it is meaningful only on completion.
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge and
// outputs are compared 1 ns later, well away from the rising edge.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramready = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk1 ({tag, "_ramREN"},  bus.ramREN,  1'b0);
        chk1 ({tag, "_ramWEN"},  bus.ramWEN,  1'b0);
        chk32({tag, "_ramaddr"}, bus.ramaddr, 32'h0);
        chk1 ({tag, "_iwait"},   bus.iwait,   1'b1);
        chk1 ({tag, "_dwait"},   bus.dwait,   1'b1);
    endtask

    initial begin
        logic        exp_ren;
        logic [31:0] exp_addr;
        logic        exp_iw;
        logic        exp_dw;

        checks = 0;
        errors = 0;
        RST    = 1'b1;
        idle_inputs();
        bus.ramload = 32'h0;

        // ---------------- reset state ----------------
        #2;
        chk_idle("rst");
        chk32("rst_ramstore", bus.ramstore, 32'h0);

        @(negedge CLK);
        RST = 1'b0;

        // ---------------- single icache read ----------------
        @(negedge CLK);
        bus.iREN    = 1'b1;
        bus.iaddr   = 32'h40;
        bus.ramload = 32'hDEADBEEF;
        #1;
        chk1("ird_req_ramREN", bus.ramREN, 1'b0);
        @(negedge CLK);
        #1;
        chk1 ("ird_c1_ramREN",  bus.ramREN,  1'b1);
        chk32("ird_c1_ramaddr", bus.ramaddr, 32'h40);
        chk1 ("ird_c1_iwait",   bus.iwait,   1'b1);
        chk1 ("ird_c1_dwait",   bus.dwait,   1'b1);
        @(negedge CLK);
        bus.ramready = 1'b1;
        #1;
        chk1 ("ird_c2_ramREN",  bus.ramREN,  1'b1);
        chk1 ("ird_c2_ramWEN",  bus.ramWEN,  1'b0);
        chk32("ird_c2_ramaddr", bus.ramaddr, 32'h40);
        chk1 ("ird_c2_iwait",   bus.iwait,   1'b0);
        chk32("ird_c2_iload",   bus.iload,   32'hDEADBEEF);
        chk1 ("ird_c2_dwait",   bus.dwait,   1'b1);
        @(negedge CLK);
        idle_inputs();
        #1;
        chk_idle("ird_bubble");

        // ---------------- dcache write (write wins over read) ----------------
        @(negedge CLK);
        bus.dWEN     = 1'b1;
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h80;
        bus.dstore   = 32'h1234;
        bus.ramready = 1'b1;
        #1;
        chk_idle("dwr_req");
        @(negedge CLK);
        #1;
        chk1 ("dwr_ramWEN",   bus.ramWEN,   1'b1);
        chk1 ("dwr_ramREN",   bus.ramREN,   1'b0);
        chk32("dwr_ramaddr",  bus.ramaddr,  32'h80);
        chk32("dwr_ramstore", bus.ramstore, 32'h1234);
        chk1 ("dwr_dwait",    bus.dwait,    1'b0);
        chk1 ("dwr_iwait",    bus.iwait,    1'b1);
        @(negedge CLK);
        #1;
        chk_idle("dwr_bubble");
        chk32("dwr_bubble_ramstore", bus.ramstore, 32'h0);
        idle_inputs();

        // ---------------- dcache read ----------------
        @(negedge CLK);
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h84;
        bus.ramready = 1'b1;
        bus.ramload  = 32'hCAFEF00D;
        @(negedge CLK);
        #1;
        chk1 ("drd_ramREN",  bus.ramREN,  1'b1);
        chk1 ("drd_ramWEN",  bus.ramWEN,  1'b0);
        chk32("drd_ramaddr", bus.ramaddr, 32'h84);
        chk1 ("drd_dwait",   bus.dwait,   1'b0);
        chk32("drd_dload",   bus.dload,   32'hCAFEF00D);
        @(negedge CLK);
        idle_inputs();

        // ---------------- contention from reset ----------------
        @(negedge CLK);
        RST          = 1'b1;
        bus.iREN     = 1'b1;
        bus.dREN     = 1'b1;
        bus.iaddr    = 32'h100;
        bus.daddr    = 32'h200;
        bus.ramready = 1'b1;
        #1;
        chk_idle("cont_rst");
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk_idle("cont_start");
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            #1;
            // Expected grant order: I, idle, D, idle, I, idle, D, idle
            case (k % 4)
                0:       begin exp_ren = 1'b1; exp_addr = 32'h100; exp_iw = 1'b0; exp_dw = 1'b1; end
                2:       begin exp_ren = 1'b1; exp_addr = 32'h200; exp_iw = 1'b1; exp_dw = 1'b0; end
                default: begin exp_ren = 1'b0; exp_addr = 32'h0;   exp_iw = 1'b1; exp_dw = 1'b1; end
            endcase
            chk1 ($sformatf("cont%0d_ramREN", k),  bus.ramREN,  exp_ren);
            chk32($sformatf("cont%0d_ramaddr", k), bus.ramaddr, exp_addr);
            chk1 ($sformatf("cont%0d_iwait", k),   bus.iwait,   exp_iw);
            chk1 ($sformatf("cont%0d_dwait", k),   bus.dwait,   exp_dw);
        end
        idle_inputs();

        // ---------------- abort during DSERV ----------------
        @(negedge CLK);
        bus.dREN  = 1'b1;
        bus.daddr = 32'h300;
        @(negedge CLK);
        #1;
        chk1 ("abt_serve_ramREN",  bus.ramREN,  1'b1);
        chk32("abt_serve_ramaddr", bus.ramaddr, 32'h300);
        chk1 ("abt_serve_dwait",   bus.dwait,   1'b1);
        @(negedge CLK);
        bus.dREN = 1'b0;
        #1;
        chk1("abt_drop_ramREN", bus.ramREN, 1'b0);
        chk1("abt_drop_dwait",  bus.dwait,  1'b1);
        @(negedge CLK);
        #1;
        chk_idle("abt_idle");
        // last still records D, so this tie goes to the icache
        bus.iREN  = 1'b1;
        bus.dREN  = 1'b1;
        bus.iaddr = 32'h100;
        bus.daddr = 32'h200;
        @(negedge CLK);
        #1;
        chk1 ("abt_tie_ramREN",  bus.ramREN,  1'b1);
        chk32("abt_tie_ramaddr", bus.ramaddr, 32'h100);

        // ---------------- reset mid-transfer (in ISERV, last=I) ----------------
        RST = 1'b1;
        #1;
        chk1 ("rmid_ramREN",  bus.ramREN,  1'b0);
        chk32("rmid_ramaddr", bus.ramaddr, 32'h0);
        chk1 ("rmid_iwait",   bus.iwait,   1'b1);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk_idle("rmid_release");
        @(negedge CLK);
        #1;
        chk1 ("rmid_tie_ramREN",  bus.ramREN,  1'b1);
        chk32("rmid_tie_ramaddr", bus.ramaddr, 32'h100);
        bus.ramready = 1'b1;
        #1;
        chk1("rmid_tie_iwait", bus.iwait, 1'b0);
        @(negedge CLK);
        idle_inputs();
        #1;
        chk_idle("rmid_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
